// File: rtl/nmea_sentence_sequencer.sv
// nmea_sentence_sequencer: byte-level sequencer for the GPZDA receive path.
// Detects '$', drives the external header comparer, strips the payload into
// numbered fields and checks the trailing NMEA XOR checksum, reporting one
// frame_ok or frame_err pulse per sentence.
module nmea_sentence_sequencer #(
  parameter int HEADER_LEN = 5,
  parameter int MAX_FIELDS = 15
) (
  input  logic       clock,
  input  logic       restart,
  input  logic       load,
  input  logic [7:0] data,
  output logic       cmp_restart,
  output logic       cmp_load,
  output logic [7:0] cmp_data,
  input  logic       cmp_resolve,
  input  logic       cmp_reject,
  output logic       field_load,
  output logic [7:0] field_data,
  output logic [3:0] field_index,
  output logic       field_end,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  localparam logic [2:0] HDR_LAST   = 3'(HEADER_LEN - 1);
  localparam logic [3:0] FIELD_LAST = 4'(MAX_FIELDS - 1);

  typedef enum logic [2:0] {
    IDLE, HEADER, SEP, FIELD, CSUM_HI, CSUM_LO
  } state_t;

  state_t     r_state, w_next_state;
  logic [2:0] r_hcnt, w_hcnt_nxt;
  logic [7:0] r_csum, w_csum_nxt;
  logic [7:4] r_rx, w_rx_nxt;
  logic [3:0] r_field_index, w_field_index_nxt;
  logic [7:0] r_field_data, w_field_data_nxt;
  logic       r_field_load, w_field_load_nxt;
  logic       r_field_end, w_field_end_nxt;
  logic       r_frame_ok, w_frame_ok_nxt;
  logic       r_frame_err, w_frame_err_nxt;

  logic       w_dollar;
  logic [4:0] w_hex;  // {valid, nibble} for the current input byte

  // Decode an uppercase ASCII hex digit; bit 4 flags a legal digit.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] res;
    res = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)
      res = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46)
      res = {1'b1, 4'(c - 8'h37)};
    return res;
  endfunction

  assign w_dollar    = load && (data == CH_DOLLAR);
  assign w_hex       = hex_nibble(data);

  // Comparer side-band is purely combinational so it sees the byte in flight.
  assign cmp_restart = restart | w_dollar;
  assign cmp_load    = load && (r_state == HEADER);
  assign cmp_data    = data;

  assign field_load  = r_field_load;
  assign field_data  = r_field_data;
  assign field_index = r_field_index;
  assign field_end   = r_field_end;
  assign frame_ok    = r_frame_ok;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != IDLE);

  // Next-state and next-output decode; '$' overrides every state.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    w_next_state      = r_state;
    w_hcnt_nxt        = r_hcnt;
    w_csum_nxt        = r_csum;
    w_rx_nxt          = r_rx;
    w_field_index_nxt = r_field_index;
    w_field_data_nxt  = r_field_data;
    w_field_load_nxt  = 1'b0;
    w_field_end_nxt   = 1'b0;
    w_frame_ok_nxt    = 1'b0;
    w_frame_err_nxt   = 1'b0;

    if (w_dollar) begin
      w_next_state    = HEADER;
      w_hcnt_nxt      = 3'd0;
      w_csum_nxt      = 8'h00;
      w_frame_err_nxt = (r_state != IDLE);
    end else begin
      case (r_state)
        IDLE: ;
        HEADER: begin
          if (cmp_reject) begin
            w_frame_err_nxt = 1'b1;
            w_next_state    = IDLE;
          end else if (load) begin
            w_csum_nxt = r_csum ^ data;
            w_hcnt_nxt = r_hcnt + 3'd1;
            if (r_hcnt == HDR_LAST) w_next_state = SEP;
          end
        end
        SEP: begin
          if (cmp_reject) begin
            w_frame_err_nxt = 1'b1;
            w_next_state    = IDLE;
          end else if (load) begin
            if (data == CH_COMMA && cmp_resolve) begin
              w_csum_nxt        = r_csum ^ data;
              w_field_index_nxt = 4'd0;
              w_next_state      = FIELD;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_next_state    = IDLE;
            end
          end
        end
        FIELD: begin
          if (load) begin
            case (data)
              CH_COMMA: begin
                if (r_field_index == FIELD_LAST) begin
                  w_frame_err_nxt = 1'b1;
                  w_next_state    = IDLE;
                end else begin
                  w_csum_nxt        = r_csum ^ data;
                  w_field_end_nxt   = 1'b1;
                  w_field_index_nxt = r_field_index + 4'd1;
                end
              end
              CH_STAR: begin
                w_field_end_nxt = 1'b1;
                w_next_state    = CSUM_HI;
              end
              CH_CR, CH_LF: begin
                w_frame_err_nxt = 1'b1;
                w_next_state    = IDLE;
              end
              default: begin
                w_csum_nxt       = r_csum ^ data;
                w_field_load_nxt = 1'b1;
                w_field_data_nxt = data;
              end
            endcase
          end
        end
        CSUM_HI: begin
          if (load) begin
            if (w_hex[4]) begin
              w_rx_nxt     = w_hex[3:0];
              w_next_state = CSUM_LO;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_next_state    = IDLE;
            end
          end
        end
        CSUM_LO: begin
          if (load) begin
            if (w_hex[4] && r_csum == {r_rx, w_hex[3:0]})
              w_frame_ok_nxt = 1'b1;
            else
              w_frame_err_nxt = 1'b1;
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State and registered outputs; restart clears everything without a report.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (restart) begin
      r_state       <= IDLE;
      r_hcnt        <= 3'd0;
      r_csum        <= 8'h00;
      r_rx          <= 4'h0;
      r_field_index <= 4'd0;
      r_field_data  <= 8'h00;
      r_field_load  <= 1'b0;
      r_field_end   <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_hcnt        <= w_hcnt_nxt;
      r_csum        <= w_csum_nxt;
      r_rx          <= w_rx_nxt;
      r_field_index <= w_field_index_nxt;
      r_field_data  <= w_field_data_nxt;
      r_field_load  <= w_field_load_nxt;
      r_field_end   <= w_field_end_nxt;
      r_frame_ok    <= w_frame_ok_nxt;
      r_frame_err   <= w_frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_nmea_sentence_sequencer.sv
// Directed bench for nmea_sentence_sequencer with a behavioural GPZDA header
// comparer attached. Inputs change 1 ns after the rising edge; outputs are
// observed on the falling edge or 1 ns after the rising edge.
module tb_nmea_sentence_sequencer;

  logic       clock = 1'b0;
  logic       restart, load;
  logic [7:0] data;
  logic       cmp_restart, cmp_load;
  logic [7:0] cmp_data;
  logic       cmp_resolve, cmp_reject;
  logic       field_load, field_end, frame_ok, frame_err, busy;
  logic [7:0] field_data;
  logic [3:0] field_index;

  int n_checks = 0;
  int n_pass   = 0;

  // Event counters written only by the monitor.
  int          n_ok = 0, n_err = 0, n_end = 0, n_rst = 0, n_both = 0;
  logic [11:0] flog[$];

  always #5 clock = ~clock;

  nmea_sentence_sequencer #(.HEADER_LEN(5), .MAX_FIELDS(15)) dut (
    .clock(clock), .restart(restart), .load(load), .data(data),
    .cmp_restart(cmp_restart), .cmp_load(cmp_load), .cmp_data(cmp_data),
    .cmp_resolve(cmp_resolve), .cmp_reject(cmp_reject),
    .field_load(field_load), .field_data(field_data),
    .field_index(field_index), .field_end(field_end),
    .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );

  // Behavioural synchronous header comparer, L=5, reference "GPZDA".
  logic [7:0] ref_hdr [0:4];
  logic [2:0] c_idx;
  initial begin
    ref_hdr[0] = 8'h47; ref_hdr[1] = 8'h50; ref_hdr[2] = 8'h5A;
    ref_hdr[3] = 8'h44; ref_hdr[4] = 8'h41;
  end
  always @(posedge clock) begin
    if (cmp_restart) begin
      c_idx <= 3'd0; cmp_resolve <= 1'b0; cmp_reject <= 1'b0;
    end else if (cmp_load && !cmp_resolve && !cmp_reject) begin
      if (cmp_data != ref_hdr[c_idx]) cmp_reject <= 1'b1;
      else if (c_idx == 3'd4)         cmp_resolve <= 1'b1;
      c_idx <= c_idx + 3'd1;
    end
  end

  // Output monitor on the falling edge.
  always @(negedge clock) begin
    if (frame_ok)               n_ok   <= n_ok + 1;
    if (frame_err)              n_err  <= n_err + 1;
    if (field_end)              n_end  <= n_end + 1;
    if (cmp_restart && !restart) n_rst <= n_rst + 1;
    if (frame_ok && frame_err)  n_both <= n_both + 1;
    if (field_load)             flog.push_back({field_index, field_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [7:0] b);
    load = 1'b1; data = b;
    @(posedge clock); #1;
  endtask

  task automatic gap(input logic [7:0] junk);
    load = 1'b0; data = junk;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    load = 1'b0; data = 8'h00;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Send a string; with gapped set, a junk cycle with load low follows
  // every byte except the last.
  task automatic send_str(input string s, input bit gapped);
    for (int i = 0; i < s.len(); i++) begin
      put(s[i]);
      if (gapped && i != s.len() - 1) gap(8'h24 ^ 8'(i));
    end
    load = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    restart = 1'b1; load = 1'b1; data = 8'h24;
    @(posedge clock); #1;
    n_checks++;
    if (cmp_restart !== 1'b1) $display("FAIL reset cmp_restart: got %b want 1", cmp_restart);
    else n_pass++;
    load = 1'b0; data = 8'h00;
    @(posedge clock); #1;
    restart = 1'b0;
    n_checks++;
    if ({field_load, field_data, field_index, field_end, frame_ok, frame_err, busy} !== 17'h0)
      $display("FAIL reset outputs: got %h want 0",
               {field_load, field_data, field_index, field_end, frame_ok, frame_err, busy});
    else n_pass++;
    idle(2);
  endtask

  task automatic test_happy(input string tag, input bit gapped);
    int ok0 = n_ok, err0 = n_err, end0 = n_end, f0 = flog.size();
    put(8'h24);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy after $: got %b want 1", tag, busy);
    else n_pass++;
    if (gapped) gap(8'hFF);
    send_str("GPZDA,1,2*4B", gapped);
    n_checks++;
    if ({frame_ok, busy} !== 2'b10) $display("FAIL %s ok/busy after last digit: got %b want 10", tag, {frame_ok, busy});
    else n_pass++;
    idle(3);
    n_checks++;
    if (n_ok - ok0 !== 1 || n_err - err0 !== 0)
      $display("FAIL %s frame counts: got ok=%0d err=%0d want ok=1 err=0", tag, n_ok - ok0, n_err - err0);
    else n_pass++;
    n_checks++;
    if (n_end - end0 !== 2) $display("FAIL %s field_end count: got %0d want 2", tag, n_end - end0);
    else n_pass++;
    n_checks++;
    if (flog.size() - f0 !== 2) $display("FAIL %s field_load count: got %0d want 2", tag, flog.size() - f0);
    else begin
      n_pass++;
      n_checks++;
      if (flog[f0] !== 12'h031 || flog[f0+1] !== 12'h132)
        $display("FAIL %s field bytes: got %h %h want 031 132", tag, flog[f0], flog[f0+1]);
      else n_pass++;
    end
  endtask

  task automatic test_bad_checksum();
    int ok0 = n_ok, err0 = n_err;
    send_str("$GPZDA,1,2*4C", 1'b0);
    n_checks++;
    if ({frame_ok, frame_err, busy} !== 3'b010) $display("FAIL badcsum ok/err/busy: got %b want 010", {frame_ok, frame_err, busy});
    else n_pass++;
    idle(3);
    n_checks++;
    if (n_ok - ok0 !== 0 || n_err - err0 !== 1)
      $display("FAIL badcsum counts: got ok=%0d err=%0d want ok=0 err=1", n_ok - ok0, n_err - err0);
    else n_pass++;
  endtask

  task automatic test_header_mismatch();
    int ok0 = n_ok, err0 = n_err, f0 = flog.size();
    send_str("$GPR", 1'b0);
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL hdrmis early err: got %b want 0", frame_err);
    else n_pass++;
    put(8'h4D);  // 'M': reject is sampled on this edge
    n_checks++;
    if ({frame_err, busy} !== 2'b10) $display("FAIL hdrmis err/busy: got %b want 10", {frame_err, busy});
    else n_pass++;
    send_str("C,1,2*4B", 1'b0);
    idle(3);
    n_checks++;
    if (n_ok - ok0 !== 0 || n_err - err0 !== 1 || flog.size() - f0 !== 0 || busy !== 1'b0)
      $display("FAIL hdrmis summary: got ok=%0d err=%0d fld=%0d busy=%b want 0 1 0 0",
               n_ok - ok0, n_err - err0, flog.size() - f0, busy);
    else n_pass++;
  endtask

  task automatic test_resync();
    int ok0 = n_ok, err0 = n_err, r0 = n_rst, f0 = flog.size();
    send_str("$GPZ$", 1'b0);
    n_checks++;
    if ({frame_err, busy} !== 2'b11) $display("FAIL resync err/busy at 2nd $: got %b want 11", {frame_err, busy});
    else n_pass++;
    send_str("GPZDA,1,2*4B", 1'b0);
    idle(3);
    n_checks++;
    if (n_ok - ok0 !== 1 || n_err - err0 !== 1)
      $display("FAIL resync counts: got ok=%0d err=%0d want ok=1 err=1", n_ok - ok0, n_err - err0);
    else n_pass++;
    n_checks++;
    if (n_rst - r0 !== 2) $display("FAIL resync cmp_restart pulses: got %0d want 2", n_rst - r0);
    else n_pass++;
    n_checks++;
    if (flog.size() - f0 !== 2) $display("FAIL resync field_load count: got %0d want 2", flog.size() - f0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_field();
    int err0 = n_err, ok0;
    send_str("$GPZDA,12", 1'b0);
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
    n_checks++;
    if ({field_load, field_data, field_index, field_end, frame_ok, frame_err, busy} !== 17'h0)
      $display("FAIL resetmid outputs: got %h want 0",
               {field_load, field_data, field_index, field_end, frame_ok, frame_err, busy});
    else n_pass++;
    idle(2);
    n_checks++;
    if (n_err - err0 !== 0) $display("FAIL resetmid frame_err count: got %0d want 0", n_err - err0);
    else n_pass++;
    ok0 = n_ok;
    send_str("$GPZDA,1,2*4B", 1'b0);
    idle(3);
    n_checks++;
    if (n_ok - ok0 !== 1) $display("FAIL resetmid follow-up frame_ok: got %0d want 1", n_ok - ok0);
    else n_pass++;
  endtask

  // 15 fields is the limit: XOR of header (0x48) and 15 commas (0x2C) is 0x64.
  task automatic test_max_fields();
    string s;
    int ok0 = n_ok, err0 = n_err, end0 = n_end;
    s = "$GPZDA,";
    for (int i = 0; i < 14; i++) s = {s, ","};
    send_str({s, "*64"}, 1'b0);
    idle(3);
    n_checks++;
    if (n_ok - ok0 !== 1 || n_err - err0 !== 0 || n_end - end0 !== 15)
      $display("FAIL maxfld at limit: got ok=%0d err=%0d end=%0d want 1 0 15",
               n_ok - ok0, n_err - err0, n_end - end0);
    else n_pass++;
    ok0 = n_ok; err0 = n_err; end0 = n_end;
    send_str({s, ",*48"}, 1'b0);
    idle(3);
    n_checks++;
    if (n_ok - ok0 !== 0 || n_err - err0 !== 1 || n_end - end0 !== 14)
      $display("FAIL maxfld overflow: got ok=%0d err=%0d end=%0d want 0 1 14",
               n_ok - ok0, n_err - err0, n_end - end0);
    else n_pass++;
  endtask

  // Malformed sentences that each end in exactly one frame_err.
  task automatic test_malformed();
    string bad[3];
    bad[0] = "$GPZDA;1,2*4B";   // wrong separator after header
    bad[1] = "$GPZDA,1,2*4b";   // lowercase hex digit
    bad[2] = "$GPZDA,1,2\r\n";  // missing checksum
    for (int i = 0; i < 3; i++) begin
      int ok0 = n_ok, err0 = n_err;
      send_str(bad[i], 1'b0);
      idle(3);
      n_checks++;
      if (n_ok - ok0 !== 0 || n_err - err0 !== 1 || busy !== 1'b0)
        $display("FAIL malformed[%0d]: got ok=%0d err=%0d busy=%b want 0 1 0",
                 i, n_ok - ok0, n_err - err0, busy);
      else n_pass++;
    end
  endtask

  initial begin
    restart = 1'b1; load = 1'b0; data = 8'h00;
    #1;
    test_reset();
    test_happy("happy", 1'b0);
    test_bad_checksum();
    test_header_mismatch();
    test_resync();
    test_happy("gapped", 1'b1);
    test_reset_mid_field();
    test_max_fields();
    test_malformed();
    n_checks++;
    if (n_both !== 0) $display("FAIL ok_and_err_same_cycle: got %0d want 0", n_both);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nmea_sentence_sequencer.md
# nmea_sentence_sequencer

Byte-level sequencer for the GPZDA receive path. It sits between the UART byte stream and the synchronous header comparer. It detects `$`, restarts the comparer and feeds it the header bytes, then gates the payload out as numbered fields. It finishes by checking the NMEA XOR checksum and reporting one `frame_ok`/`frame_err` pulse per sentence.

## Interface
- `HEADER_LEN`, default 5, number of header bytes after `$` forwarded to the comparer ("GPZDA").
- `MAX_FIELDS`, default 15, maximum field count; `field_index` is 4 bits wide.
- `clock` in 1, single system clock; all logic on the rising edge.
- `restart` in 1, reset, synchronous, active-high.
- `load` in 1, input byte strobe, one byte per asserted cycle; back-to-back allowed.
- `data` in 8, input byte (ASCII).
- `cmp_restart` out 1, comparer restart (combinational).
- `cmp_load` out 1, comparer byte strobe (combinational).
- `cmp_data` out 8, comparer byte, equal to `data`.
- `cmp_resolve` in 1, comparer match; level, valid from the cycle after the deciding byte, held until `cmp_restart`.
- `cmp_reject` in 1, comparer mismatch; same timing as `cmp_resolve`.
- `field_load` out 1, strobe for one payload byte.
- `field_data` out 8, the payload byte.
- `field_index` out 4, index of the current field (0-based).
- `field_end` out 1, pulse when a field is terminated by `,` or `*`.
- `frame_ok` out 1, pulse: sentence complete and checksum matches.
- `frame_err` out 1, pulse: sentence aborted or checksum mismatch.
- `busy` out 1, high whenever the state is not IDLE.

## Operation
- States: IDLE, HEADER, SEP, FIELD, CSUM_HI, CSUM_LO.
- Header byte counter: 3 bits. Running checksum register `csum[7:0]`. Received checksum register `rx[7:0]`.
- Combinational comparer outputs:
  - `cmp_restart = restart | (load & data=="$")`.
  - `cmp_load = load & state==HEADER`.
  - `cmp_data = data`.
- `$` handling (any state): go to HEADER, clear `csum` and the counter.
  - If the state was not IDLE, also pulse `frame_err`; the old sentence is abandoned.
- IDLE: every byte except `$` is ignored.
- HEADER:
  - Each load XORs the byte into `csum` and increments the counter.
  - On the `HEADER_LEN`-th byte, go to SEP.
  - `cmp_reject` high in any HEADER cycle gives `frame_err` and IDLE; this is an early mismatch.
- SEP:
  - `cmp_reject` gives `frame_err` and IDLE.
  - A load of `,` with `cmp_resolve` high XORs `,`, sets `field_index` to 0 and goes to FIELD.
  - A load of any other byte, or of `,` while `cmp_resolve` is low, gives `frame_err` and IDLE.
- FIELD:
  - An ordinary byte XORs into `csum` and pulses `field_load` with `field_data` set to the byte.
  - `,` XORs into `csum`, pulses `field_end` and increments `field_index`. If `field_index` is already `MAX_FIELDS-1`, the result is `frame_err` and IDLE instead.
  - `*` pulses `field_end` (not XORed) and goes to CSUM_HI.
  - CR or LF gives `frame_err` and IDLE (missing checksum).
- CSUM_HI and CSUM_LO:
  - Accept only `0`-`9` and `A`-`F` (uppercase); any other byte gives `frame_err` and IDLE.
  - CSUM_HI stores the high nibble in `rx[7:4]`.
  - CSUM_LO compares `csum` with {`rx[7:4]`, nibble}: equal gives `frame_ok`, otherwise `frame_err`. Both go to IDLE.
- Exactly one `frame_ok` or `frame_err` per sentence started by `$`; never both in the same cycle.

## Timing
- Reset value of every registered output is 0: `field_load`, `field_data`, `field_index`, `field_end`, `frame_ok`, `frame_err`, `busy`. State resets to IDLE.
  - `cmp_restart` is 1 while `restart` is high.
  - Reset mid-sentence aborts silently, with no `frame_err`.
- Registered outputs assert in the cycle after the sampled `load` that causes them, for exactly one cycle.
  - This covers `field_*`, `frame_ok` and `frame_err`.
  - A `frame_err` caused by `cmp_reject` asserts in the cycle after `cmp_reject` is sampled.
- `busy` goes high the cycle after `$` and low the cycle after the last checksum digit, or in the same cycle as `frame_err`.
- Back-to-back bytes are processed at one per cycle with no stall.
  - The comparer result for the last header byte is valid exactly when the next byte can arrive, so SEP samples `cmp_resolve` in the same cycle as the `,`.
- `restart` dominates `load` in the same cycle.
- `$` dominates every other rule in every state.

## Test plan
- Bench setup: the team's synchronous comparer with L=5 and Ref "GPZDA".
- Happy path: back-to-back "$GPZDA,1,2*4B".
  - Required: `field_load` for `1` (index 0) and `2` (index 1).
  - Required: `field_end` after the first `,` and after `*`.
  - Required: one `frame_ok`; `busy` low afterwards.
- Bad checksum: "$GPZDA,1,2*4C" gives one `frame_err` and no `frame_ok`.
- Header mismatch: "$GPRMC,..." gives `frame_err` after `R` is rejected; no `field_load` ever occurs and the state is IDLE.
- Resync: "$GPZ$GPZDA,1,2*4B" gives `frame_err` at the second `$`, then `frame_ok`. `cmp_restart` pulses twice.
- Gapped strobes with junk: the same sentence with `load` low on alternate cycles and `data` toggled to garbage while `load` is low gives an identical result to the happy path.
- Reset mid-field: `restart` held for 1 cycle after "$GPZDA,12" leaves all outputs at 0 and `busy` at 0, with no `frame_err`. A following valid sentence gives `frame_ok`.
